alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//  Multi-cycle unsigned shift-add multiplier sequencer built around the team's
//  N-bit ripple ALU (module ALU). Accepts two N-bit operands on a start/busy/done
//  handshake and drives one ALU instance for N iterations to form a 2N-bit product.
//  Sits between the control unit and the ALU; it is the ALU's sole owner while busy.
// PARAMETERS
//  N       4       operand width; ALU instantiated with n=N; N>=2
//  OP_ADD  3'b010  ALU cntrl code for A+B; bit0 is the carry-in and must be 0
// PORTS
//  clk      in   1   single clock, all state on rising edge
//  rst      in   1   synchronous, active-high reset
//  start    in   1   request; sampled only in IDLE or DONE
//  a        in   N   multiplicand, captured on the accepted start
//  b        in   N   multiplier, captured on the accepted start
//  busy     out  1   high while state==ITER
//  done     out  1   one-cycle pulse, product valid
//  product  out  2N  registered result; held until next completion
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, product=0, acc_hi=0, acc_lo=0, mcand=0, cnt=0.
//  Internal regs: mcand[N-1:0], acc_hi[N-1:0], acc_lo[N-1:0] (holds multiplier),
//   cnt[$clog2(N+1)-1:0].
//  FSM IDLE/ITER/DONE:
//   IDLE: start=1 -> mcand<=a, acc_lo<=b, acc_hi<=0, cnt<=0, ->ITER; else stay.
//   ITER: ALU a=acc_hi, b=(acc_lo[0] ? mcand : 0), cntrl=OP_ADD; each edge
//    {acc_hi,acc_lo} <= {alu_cout, alu_f, acc_lo[N-1:1]}; cnt<=cnt+1.
//    On the edge where cnt==N-1: product <= shifted value, ->DONE.
//   DONE: done=1 for exactly this cycle; start=1 -> capture as in IDLE, ->ITER
//    (back-to-back); else ->IDLE.
//  Outside ITER the ALU cntrl is driven to OP_ADD with b=0 (output ignored).
//  Latency: start sampled at edge k -> done high in the cycle after edge k+N;
//   throughput one product per N+1 cycles.
//  ALU carry-out is the (N+1)-th sum bit; never dropped, so no overflow is possible.
//   ALU overflow output v is left unconnected.
//  start while busy: ignored, no queuing, operands not re-captured.
//  a/b may change freely after the accepting edge.
//  product changes only on the final ITER edge; it holds its old value while busy.
//  rst mid-ITER: abort, return to IDLE next edge, product cleared to 0, no done.
//  a=0 or b=0: still takes N iterations (no early exit); product=0.
// STRUCTURE
//  Shared package alu_pkg: ALU cntrl opcode constants (OP_ADD, OP_SUB, logic ops)
//   and the FSM state encoding localparams (IDLE=2'd0, ITER=2'd1, DONE=2'd2).
//  One sub-module: ALU (n=N) instantiated once.
//  The FSM, counter and shift register stay in this module; no further split.
// TESTING (N=4, OP_ADD default)
//  1. rst 3 cycles -> busy=0, done=0, product=8'h00.
//  2. a=13, b=11, start 1 cycle -> busy for 4 cycles, done pulse 4 cycles after
//     the accepting edge, product=8'h8F, held after done.
//  3. a=15, b=15 -> product=8'hE1 (exercises carry-out every iteration);
//     a=0, b=9 -> 8'h00 after the same latency.
//  4. start held high with new a/b during ITER -> ignored; product matches the
//     originally captured operands.
//  5. start high in the DONE cycle with a=3, b=5 -> re-enters ITER with no IDLE
//     gap; second done 5 cycles after the first; product=8'h0F.
//  6. rst asserted on the 2nd ITER cycle -> no done; product=8'h00; state IDLE;
//     a new start completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and multiplier-sequencer state encoding.
// cntrl[2:1] selects the function; cntrl[0] is the adder carry-in (and B-invert).
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/ALU.sv
// N-bit ripple-carry ALU: AND / ADD / SUB / OR / XOR selected by cntrl.
// Carry-out and signed overflow are meaningful only for the arithmetic ops.
module ALU #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  logic [2:0]   i_cntrl,
    output logic [n-1:0] o_f,
    output logic         o_cout,
    output logic         o_v
);

    logic [n-1:0] w_b_eff;
    logic [n-1:0] w_sum;
    logic [n:0]   w_c;

    // SUB reuses the adder as A + ~B + 1
    assign w_b_eff = i_cntrl[0] ? ~i_b : i_b;
    assign w_c[0]  = i_cntrl[0];

    for (genvar g = 0; g < n; g++) begin : g_fa
        assign w_sum[g]  = i_a[g] ^ w_b_eff[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & w_b_eff[g]) | (w_c[g] & (i_a[g] ^ w_b_eff[g]));
    end

    always_comb begin
        o_f    = '0;
        o_cout = 1'b0;
        o_v    = 1'b0;
        case (i_cntrl[2:1])
            2'b00: o_f = i_a & i_b;
            2'b01: begin
                o_f    = w_sum;
                o_cout = w_c[n];
                o_v    = w_c[n] ^ w_c[n-1];
            end
            2'b10: o_f = i_a | i_b;
            default: o_f = i_a ^ i_b;
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-add multiplier driving one ripple ALU for N iterations.
// The multiplier sits in acc_lo and is shifted out LSB-first as product bits shift in.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter logic [2:0]  OP_ADD = alu_pkg::OP_ADD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = $clog2(N + 1);

    seq_state_e r_state;
    seq_state_e w_state_d;

    logic [N-1:0]   r_mcand;
    logic [N-1:0]   r_acc_hi;
    logic [N-1:0]   r_acc_lo;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_product;

    logic [N-1:0]   w_alu_b;
    logic [N-1:0]   w_alu_f;
    logic           w_alu_cout;
    logic [2*N-1:0] w_shift;
    logic           w_last;

    assign w_alu_b = ((r_state == ITER) && r_acc_lo[0]) ? r_mcand : '0;
    assign w_shift = {w_alu_cout, w_alu_f, r_acc_lo[N-1:1]};
    assign w_last  = (r_cnt == CW'(N - 1));

    ALU #(
        .n (N)
    ) u_alu (
        .i_a     (r_acc_hi),
        .i_b     (w_alu_b),
        .i_cntrl (OP_ADD),
        .o_f     (w_alu_f),
        .o_cout  (w_alu_cout),
        .o_v     ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (start) w_state_d = ITER;
            ITER:    if (w_last) w_state_d = DONE;
            DONE:    w_state_d = start ? ITER : IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_acc_lo <= b;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                    end
                end
                ITER: begin
                    {r_acc_hi, r_acc_lo} <= w_shift;
                    r_cnt                <= r_cnt + CW'(1);
                    if (w_last) r_product <= w_shift;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state == ITER);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq (N=4) with hand-computed products.
module tb_alu_mul_seq;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mul_seq #(
        .N (N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one multiply, wait (bounded) for done, check latency and product.
    task automatic do_mul(input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic [2*N-1:0] exp, input string tag);
        int cyc;
        a     = ia;
        b     = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ia;
        b     = ~ib;
        cyc   = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check_eq({tag, "_lat"}, cyc, 4);
        check_eq({tag, "_prod"}, {24'h0, product}, {24'h0, exp});
    endtask

    initial begin
        int cyc;
        logic saw_done;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2;

        // 1. reset
        repeat (3) tick();
        check_eq("rst_busy", {31'h0, busy}, 0);
        check_eq("rst_done", {31'h0, done}, 0);
        check_eq("rst_prod", {24'h0, product}, 32'h00);
        rst = 1'b0;
        tick();

        // 2. 13*11, cycle by cycle
        a = 4'd13; b = 4'd11; start = 1'b1;
        tick();
        start = 1'b0; a = 4'd0; b = 4'd0;
        check_eq("t2_busy0", {31'h0, busy}, 1);
        check_eq("t2_prod_hold", {24'h0, product}, 32'h00);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_eq("t2_busy", {31'h0, busy}, 1);
            check_eq("t2_nodone", {31'h0, done}, 0);
        end
        tick();
        check_eq("t2_done", {31'h0, done}, 1);
        check_eq("t2_busy_off", {31'h0, busy}, 0);
        check_eq("t2_prod", {24'h0, product}, 32'h8F);
        tick();
        check_eq("t2_done_pulse", {31'h0, done}, 0);
        check_eq("t2_prod_held", {24'h0, product}, 32'h8F);

        // 3. carry-out every iteration, zero operand
        do_mul(4'd15, 4'd15, 8'hE1, "t3_ff");
        tick();
        do_mul(4'd0, 4'd9, 8'h00, "t3_zero");
        tick();
        do_mul(4'd9, 4'd0, 8'h00, "t3_zero_b");
        tick();

        // 4. start held during ITER with different operands is ignored
        a = 4'd7; b = 4'd9; start = 1'b1;
        tick();
        a = 4'd2; b = 4'd2;
        for (int i = 1; i < 4; i++) begin
            tick();
            check_eq("t4_busy", {31'h0, busy}, 1);
        end
        start = 1'b0;
        tick();
        check_eq("t4_done", {31'h0, done}, 1);
        check_eq("t4_prod", {24'h0, product}, 32'h3F);
        tick();
        tick();

        // 5. back-to-back: start in the DONE cycle
        do_mul(4'd2, 4'd6, 8'h0C, "t5_first");
        a = 4'd3; b = 4'd5; start = 1'b1;
        tick();
        start = 1'b0; a = 4'd0; b = 4'd0;
        check_eq("t5_no_gap", {31'h0, busy}, 1);
        check_eq("t5_prod_hold", {24'h0, product}, 32'h0C);
        cyc = 1;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check_eq("t5_spacing", cyc, 5);
        check_eq("t5_prod", {24'h0, product}, 32'h0F);
        tick();

        // 6. reset during the second ITER cycle aborts the multiply
        a = 4'd13; b = 4'd11; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("t6_busy_pre", {31'h0, busy}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_busy", {31'h0, busy}, 0);
        check_eq("t6_prod", {24'h0, product}, 32'h00);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_done = saw_done | done | busy;
        end
        check_eq("t6_idle", {31'h0, saw_done}, 0);
        do_mul(4'd9, 4'd9, 8'h51, "t6_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
